// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the program counter unit
package pc_pkg;

    // Source of the next PC, supplied by the control unit.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } pc_mode_e;

    // Sequencer state; fault and halted outputs decode directly from it.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEFAULT_PC_INCREMENT = 4;

endpackage

// File: rtl/imm_gen_bj.sv
// rtl/imm_gen_bj.sv - combinational B-type and J-type immediate decoder
//
// Ports:
//   instr  in   32    raw instruction word
//   imm_b  out  XLEN  sign-extended branch offset
//   imm_j  out  XLEN  sign-extended jump offset
module imm_gen_bj #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_j
);

    // Both offsets are even; bit 0 is an implied zero.
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};

    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    // The opcode field carries no immediate bits.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with branch/jump targets, stall, halt and fault
//
// Ports:
//   clk, arst_n   clock (rising edge) and asynchronous active-low reset
//   instr         instruction word, source of the B/J immediates
//   alu_res       bit0 = branch condition, full value = JALR target
//   pc_mode       SEQ / BRANCH / JAL / JALR
//   br_neg        invert branch condition
//   stall         hold PC this cycle
//   halt, resume  enter / leave the HALT state
//   redirect      load redirect_pc from any state
//   redirect_pc   redirect target (not alignment-checked)
//   pc_out        current PC
//   pc_link       pc_out + PC_INCREMENT
//   taken         a non-sequential update happened on the last edge
//   fault         FAULT state active
//   fault_addr    misaligned target captured on entry to FAULT
//   halted        HALT state active
module pc_unit
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int               PC_INCREMENT = DEFAULT_PC_INCREMENT,
    parameter int               ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] alu_res,
    input  pc_mode_e        pc_mode,
    input  logic            br_neg,
    input  logic            stall,
    input  logic            halt,
    input  logic            resume,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_link,
    output logic            taken,
    output logic            fault,
    output logic [XLEN-1:0] fault_addr,
    output logic            halted
);

    localparam logic [XLEN-1:0] INC = XLEN'(PC_INCREMENT);

    pc_state_e       state_q, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic            taken_q, taken_nxt;
    logic [XLEN-1:0] fault_addr_q, fault_addr_nxt;

    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;
    logic            cond;
    logic            nonseq;
    logic            misaligned;

    imm_gen_bj #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (instr),
        .imm_b (imm_b),
        .imm_j (imm_j)
    );

    assign seq_pc = pc_q + INC;
    assign cond   = alu_res[0] ^ br_neg;

    // Target selection; nonseq marks updates that leave the sequential stream.
    always_comb begin
        target = seq_pc;
        nonseq = 1'b0;
        case (pc_mode)
            PC_SEQ: begin
                target = seq_pc;
                nonseq = 1'b0;
            end
            PC_BRANCH: begin
                target = cond ? (pc_q + imm_b) : seq_pc;
                nonseq = cond;
            end
            PC_JAL: begin
                target = pc_q + imm_j;
                nonseq = 1'b1;
            end
            PC_JALR: begin
                target = {alu_res[XLEN-1:1], 1'b0};
                nonseq = 1'b1;
            end
            default: begin
                target = seq_pc;
                nonseq = 1'b0;
            end
        endcase
    end

    // Only taken non-sequential targets are checked, so a not-taken branch
    // with an odd offset never faults.
    assign misaligned = nonseq && (target[ALIGN_BITS-1:0] != '0);

    always_comb begin
        state_nxt      = state_q;
        pc_nxt         = pc_q;
        taken_nxt      = 1'b0;
        fault_addr_nxt = fault_addr_q;
        if (redirect) begin
            state_nxt = ST_RUN;
            pc_nxt    = redirect_pc;
            taken_nxt = 1'b1;
        end else begin
            case (state_q)
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                ST_HALT: begin
                    // Resume only changes state; the PC moves on the next edge.
                    if (resume) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state_nxt = ST_HALT;
                    end else if (stall) begin
                        state_nxt = ST_RUN;
                    end else if (misaligned) begin
                        state_nxt      = ST_FAULT;
                        fault_addr_nxt = target;
                    end else begin
                        pc_nxt    = target;
                        taken_nxt = nonseq;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_VECTOR;
            taken_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_nxt;
            pc_q         <= pc_nxt;
            taken_q      <= taken_nxt;
            fault_addr_q <= fault_addr_nxt;
        end
    end

    assign pc_out     = pc_q;
    assign pc_link    = seq_pc;
    assign taken      = taken_q;
    assign fault      = (state_q == ST_FAULT);
    assign fault_addr = fault_addr_q;
    assign halted     = (state_q == ST_HALT);

endmodule
